// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso transmitter: FSM encoding and counter sizing.
package piso_tx_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Bit-counter width for a word of the given width; shared with sipo.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Word handshake, enables and serial-side signals of the piso transmitter.
interface piso_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             ie;
    logic             oe;
    logic             q;
    logic             busy;
    logic             first;
    logic             last;

    modport master (
        output din, load, ie, oe,
        input  ready, q, busy, first, last
    );

    modport slave (
        input  din, load, ie, oe,
        output ready, q, busy, first, last
    );
endinterface

// File: rtl/piso_buf.sv
// One-entry holding register that lets the next word queue behind the one shifting out.
module piso_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr,
    input  logic             rd,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic             ready
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    // rd and wr never coincide: wr needs ready, rd needs full.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (rd) begin
            full_d = 1'b0;
        end
        if (wr) begin
            data_d = din;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data  = data_q;
    assign full  = full_q;
    assign ready = !full_q;
endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with a one-word buffer for gapless streaming.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    piso_tx_if.slave   bus
);
    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] buf_data;
    logic             buf_full;
    logic             buf_ready;
    logic             buf_wr;
    logic             buf_rd;
    logic             final_consume;
    logic             out_bit;

    assign final_consume = (state_q == ST_SHIFT) && bus.ie && (cnt_q == CNT_LAST);
    assign buf_rd        = final_consume && buf_full;
    // A word offered on the final-bit edge goes straight to the shift register.
    assign buf_wr        = (state_q == ST_SHIFT) && bus.load && buf_ready && !final_consume;

    piso_buf #(.WIDTH(WIDTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.din),
        .wr    (buf_wr),
        .rd    (buf_rd),
        .data  (buf_data),
        .full  (buf_full),
        .ready (buf_ready)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.load && buf_ready) begin
                    sreg_d  = bus.din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (bus.ie) begin
                    if (cnt_q != CNT_LAST) begin
                        sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                           : {1'b0, sreg_q[WIDTH-1:1]};
                        cnt_d  = cnt_q + CW'(1);
                    end else if (buf_full) begin
                        sreg_d = buf_data;
                        cnt_d  = '0;
                    end else if (bus.load && buf_ready) begin
                        sreg_d = bus.din;
                        cnt_d  = '0;
                    end else begin
                        sreg_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_bit   = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign bus.busy  = (state_q == ST_SHIFT);
    assign bus.q     = bus.oe && bus.busy && out_bit;
    assign bus.first = bus.busy && (cnt_q == '0);
    assign bus.last  = bus.busy && (cnt_q == CNT_LAST);
    assign bus.ready = buf_ready;
endmodule
